// File: rtl/adder_sum_collector.sv
// adder_sum_collector
//   Collects COUNT results from the 4-bit ripple-carry adder. Each result is
//   taken as the unsigned value {cout, sum}. The samples are summed into a
//   saturating ACC_W-bit total, and the batch total is presented on a held
//   valid/ready output.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   clear      synchronous batch abort (ignored in IDLE)
//   in_valid   upstream sample valid
//   in_ready   collector accepts a sample this cycle
//   in_sum     adder sum, DATA_W bits
//   in_cout    adder carry-out
//   out_valid  batch result valid (held until out_ready)
//   out_ready  downstream accepts the result
//   out_acc    batch total, saturated to all-ones
//   out_ovf    saturation happened somewhere in this batch
//
// Every output is either a register or a decode of the state register, so
// there is no combinational path from any input to any output.
module adder_sum_collector #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 12,   // must be >= DATA_W+1
    parameter int COUNT  = 8     // 1..255, fits the 8-bit sample counter
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_sum,
    input  logic              in_cout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_ovf
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    // The COUNT-th handshake arrives while cnt still holds COUNT-1.
    localparam logic [7:0] CNT_LAST = 8'(COUNT - 1);

    logic [1:0]        state;
    logic [ACC_W-1:0]  acc;
    logic [7:0]        cnt;
    logic              ovf;

    logic [DATA_W:0]   sample;
    logic [ACC_W:0]    sum;
    logic              in_hs;
    logic              out_hs;

    assign in_ready  = (state == S_ACCUM);
    assign out_valid = (state == S_HOLD);
    assign out_acc   = acc;
    assign out_ovf   = ovf;

    assign in_hs  = in_valid & in_ready;
    assign out_hs = out_valid & out_ready;

    // Treat the adder result as an unsigned (DATA_W+1)-bit value. Add it one
    // bit wider than the accumulator so that the top bit flags an overflow.
    assign sample = {in_cout, in_sum};
    assign sum    = {1'b0, acc} + {{(ACC_W - DATA_W){1'b0}}, sample};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                // One idle cycle after reset release, then start collecting.
                S_IDLE: begin
                    state <= S_ACCUM;
                end

                S_ACCUM: begin
                    if (clear) begin
                        // Abort wins over a sample arriving in the same cycle.
                        acc <= '0;
                        cnt <= '0;
                        ovf <= 1'b0;
                    end else if (in_hs) begin
                        if (sum[ACC_W]) begin
                            // Saturate. Later additions overflow again and
                            // keep acc pinned at all-ones. ovf stays sticky.
                            acc <= '1;
                            ovf <= 1'b1;
                        end else begin
                            acc <= sum[ACC_W-1:0];
                        end
                        cnt <= cnt + 8'd1;
                        if (cnt == CNT_LAST) begin
                            state <= S_HOLD;
                        end
                    end
                end

                S_HOLD: begin
                    // A result taken in the same cycle as clear is dropped.
                    // Both cases restart an empty batch.
                    if (clear || out_hs) begin
                        state <= S_ACCUM;
                        acc   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_sum_collector.sv
// Bench for adder_sum_collector. Three instances share one stimulus stream:
//   u0 uses the default parameters, u1 uses ACC_W=6, u2 uses COUNT=1.
// A per-instance model keeps the list of samples accepted into the current
// batch. The expected handshake signals and the totals are derived from that
// list on each falling edge.
module tb_adder_sum_collector;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [3:0] in_sum = '0;
    logic in_cout = 1'b0;

    logic [NI-1:0] rdy, ov, ovf;
    logic [11:0] acc0, acc2;
    logic [5:0]  acc1;
    logic [11:0] oacc [NI];

    assign oacc[0] = acc0;
    assign oacc[1] = {6'd0, acc1};
    assign oacc[2] = acc2;

    int cnt_p [NI] = '{8, 8, 1};
    int max_p [NI] = '{4095, 63, 4095};

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    adder_sum_collector u0 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(rdy[0]), .in_sum(in_sum), .in_cout(in_cout),
        .out_valid(ov[0]), .out_ready(out_ready), .out_acc(acc0), .out_ovf(ovf[0])
    );

    adder_sum_collector #(.ACC_W(6)) u1 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(rdy[1]), .in_sum(in_sum), .in_cout(in_cout),
        .out_valid(ov[1]), .out_ready(out_ready), .out_acc(acc1), .out_ovf(ovf[1])
    );

    adder_sum_collector #(.COUNT(1)) u2 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(rdy[2]), .in_sum(in_sum), .in_cout(in_cout),
        .out_valid(ov[2]), .out_ready(out_ready), .out_acc(acc2), .out_ovf(ovf[2])
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Wait for the next rising edge, then move 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    int bq [NI][$];   // samples accepted into the current batch
    bit idle [NI];    // first cycle after reset release

    always @(negedge clk) begin
        int  tot;
        bit  full;
        bit  er;
        for (int i = 0; i < NI; i++) begin
            if (!rst) begin
                bq[i].delete();
                idle[i] = 1'b1;
                chk($sformatf("rst_in_ready[%0d]", i), rdy[i], 0);
                chk($sformatf("rst_out_valid[%0d]", i), ov[i], 0);
                chk($sformatf("rst_out_acc[%0d]", i), oacc[i], 0);
                chk($sformatf("rst_out_ovf[%0d]", i), ovf[i], 0);
            end else begin
                full = (bq[i].size() == cnt_p[i]);
                er   = !idle[i] && !full;
                chk($sformatf("in_ready[%0d]", i), rdy[i], er);
                chk($sformatf("out_valid[%0d]", i), ov[i], full);
                if (full) begin
                    tot = 0;
                    foreach (bq[i][k]) tot += bq[i][k];
                    chk($sformatf("out_acc[%0d]", i), oacc[i], (tot > max_p[i]) ? max_p[i] : tot);
                    chk($sformatf("out_ovf[%0d]", i), ovf[i], (tot > max_p[i]) ? 1 : 0);
                end
                // Apply the edge that follows this sampling point.
                if (idle[i])                 idle[i] = 1'b0;
                else if (clear)              bq[i].delete();
                else if (full && out_ready)  bq[i].delete();
                else if (er && in_valid)     bq[i].push_back(int'({in_cout, in_sum}));
            end
        end
    end

    // Hold in_valid with value v until u0 has accepted n samples.
    task automatic feed(input int v, input int n);
        int got = 0;
        int g = 0;
        in_valid = 1'b1;
        {in_cout, in_sum} = 5'(v);
        while (got < n && g < 200) begin
            if (rdy[0]) got++;
            tick();
            g++;
        end
        in_valid = 1'b0;
        chk("feed_accepts", got, n);
    endtask

    typedef struct {
        int v;    // sample value repeated 8 times
        int e0;   // expected u0 total
        int e1;   // expected u1 total (ACC_W=6)
        int f1;   // expected u1 overflow flag
    } vec_t;

    vec_t tbl [6];
    int   v6 [3] = '{5, 7, 9};

    initial begin
        tbl[0] = '{31, 248, 63, 1};
        tbl[1] = '{1,  8,   8,  0};
        tbl[2] = '{7,  56,  56, 0};
        tbl[3] = '{8,  64,  63, 1};
        tbl[4] = '{0,  0,   0,  0};
        tbl[5] = '{15, 120, 63, 1};

        repeat (3) tick();
        rst = 1'b1;
        chk("idle_in_ready", rdy[0], 0);
        tick();
        chk("accum_in_ready", rdy[0], 1);

        // Constant batches, with out_ready held high the whole time.
        out_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            feed(tbl[t].v, 8);
            chk("tbl_out_valid", ov[0], 1);
            chk("tbl_acc0", acc0, tbl[t].e0);
            chk("tbl_ovf0", ovf[0], 0);
            chk("tbl_acc1", acc1, tbl[t].e1);
            chk("tbl_ovf1", ovf[1], tbl[t].f1);
            tick();
            chk("tbl_out_valid_drop", ov[0], 0);
            chk("tbl_in_ready_back", rdy[0], 1);
        end

        // Samples 1..8 with a gap after each one, and a stalled output.
        out_ready = 1'b0;
        begin
            int k = 1;
            int g = 0;
            while (k <= 8 && g < 100) begin
                in_valid = 1'b1;
                {in_cout, in_sum} = 5'(k);
                if (rdy[0]) k++;
                tick();
                in_valid = 1'b0;
                tick();
                g++;
            end
            chk("gap_accepts", k, 9);
        end
        chk("gap_out_valid", ov[0], 1);
        repeat (5) begin
            chk("hold_acc", acc0, 36);
            chk("hold_in_ready", rdy[0], 0);
            tick();
        end
        out_ready = 1'b1;
        chk("hold_out_valid", ov[0], 1);
        tick();
        out_ready = 1'b0;
        chk("hold_release", ov[0], 0);
        chk("hold_in_ready_back", rdy[0], 1);

        // Clear arriving in the same cycle as a sample.
        out_ready = 1'b1;
        in_valid = 1'b1;
        {in_cout, in_sum} = 5'd10;
        repeat (3) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clear_acc", acc0, 0);
        chk("clear_in_ready", rdy[0], 1);
        feed(2, 8);
        chk("clear_out_valid", ov[0], 1);
        chk("clear_batch_acc", acc0, 16);
        tick();

        // Reset while a result is held.
        out_ready = 1'b0;
        feed(31, 8);
        chk("prerst_acc", acc0, 248);
        rst = 1'b0;
        #1;
        chk("async_rst_out_valid", ov[0], 0);
        chk("async_rst_out_acc", acc0, 0);
        tick();
        tick();
        rst = 1'b1;
        chk("rst_release_in_ready", rdy[0], 0);
        tick();
        chk("rst_after_in_ready", rdy[0], 1);
        out_ready = 1'b1;
        feed(1, 8);
        chk("post_rst_acc", acc0, 8);
        chk("post_rst_out_valid", ov[0], 1);
        tick();

        // COUNT=1: every sample is its own batch.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            int g = 0;
            {in_cout, in_sum} = 5'(v6[i]);
            while (!rdy[2] && g < 10) begin tick(); g++; end
            tick();
            chk("c1_out_valid", ov[2], 1);
            chk("c1_acc", acc2, v6[i]);
            chk("c1_in_ready_gap", rdy[2], 0);
            tick();
            chk("c1_out_valid_drop", ov[2], 0);
            chk("c1_in_ready_back", rdy[2], 1);
        end
        in_valid = 1'b0;

        // Random traffic, checked by the model on every cycle.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            {in_cout, in_sum} = 5'($urandom_range(0, 31));
            out_ready = ($urandom_range(0, 2) != 0);
            clear     = ($urandom_range(0, 60) == 0);
            rst       = ($urandom_range(0, 400) != 0);
            tick();
        end
        rst = 1'b1;
        clear = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
